// File: rtl/ram_io_responder.sv
// Responder for the byte-serial memory bus: on-chip RAM below the I/O bit,
// TX/RX byte FIFOs to a serial link above it, and the global CPU ready.
module ram_io_responder #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned RAM_ADDR_BITS   = 17,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_wr_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic [7:0]            ram_data_i,
  output logic [7:0]            ram_data_o,
  output logic                  rdy_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_STAT = 3'd4;

  logic [7:0] mem    [2 ** RAM_ADDR_BITS];
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];

  logic [FIFO_DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   tx_count, rx_count;
  logic [ADDR_WIDTH-1:0]      prev_addr;
  logic                       prev_wr;

  logic                     tx_full, rx_nonempty, is_io;
  logic [2:0]               offset;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic                     tx_push, tx_pop, rx_push, rx_pop, pop_ev;
  logic                     io_load;
  logic [7:0]               io_value;

  assign tx_full     = (tx_count == FULL);
  assign rdy_o       = !tx_full;
  assign tx_valid_o  = (tx_count != '0);
  assign tx_data_o   = tx_valid_o ? tx_mem[tx_rd_ptr] : '0;
  assign rx_ready_o  = (rx_count != FULL);
  assign rx_nonempty = (rx_count != '0);

  assign is_io   = ram_addr_i[RAM_ADDR_BITS];
  assign offset  = ram_addr_i[2:0];
  assign ram_idx = ram_addr_i[RAM_ADDR_BITS-1:0];

  assign tx_push = rdy_o && ram_wr_i && is_io && (offset == OFF_DATA);
  assign tx_pop  = tx_valid_o && tx_ready_i;
  assign rx_push = rx_valid_i && rx_ready_o;
  // A held DATA read pops only on its first accepted cycle; repeats replay the byte.
  assign pop_ev  = rdy_o && !ram_wr_i && is_io && (offset == OFF_DATA) &&
                   (prev_wr || (prev_addr != ram_addr_i));
  assign rx_pop  = pop_ev && rx_nonempty;

  always_comb begin
    io_load  = 1'b1;
    io_value = '0;
    if (offset == OFF_DATA) begin
      io_load  = pop_ev;
      io_value = rx_nonempty ? rx_mem[rx_rd_ptr] : '0;
    end else if (offset == OFF_STAT) begin
      io_value = {6'b0, tx_full, rx_nonempty};
    end
  end

  // Storage arrays carry no reset; writes are suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (rst && rdy_o && ram_wr_i && !is_io) mem[ram_idx] <= ram_data_i;
    if (rst && tx_push)                     tx_mem[tx_wr_ptr] <= ram_data_i;
    if (rst && rx_push)                     rx_mem[rx_wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_data_o <= '0;
      prev_addr  <= '0;
      prev_wr    <= 1'b1;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
    end else begin
      if (rdy_o) begin
        prev_addr <= ram_addr_i;
        prev_wr   <= ram_wr_i;
        if (!ram_wr_i) begin
          if (!is_io)       ram_data_o <= mem[ram_idx];
          else if (io_load) ram_data_o <= io_value;
        end
      end

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      unique case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
